// File: rtl/mem_load_unit.sv
// Sequential load unit: issues one or two beat-aligned reads, merges the beats,
// then extracts and sign/zero-extends a byte, half, word or doubleword field.
module mem_load_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int BIG_ENDIAN  = 1,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, RESP} state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   base_r;
  logic [OFF_W-1:0]    off_r;
  logic [3:0]          nbytes_r;
  logic                uns_r;
  logic                split_r;
  logic [DATA_W-1:0]   beat0_r;
  logic                req_ready_r;
  logic                mem_rd_en_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_err_r;

  logic [OFF_W-1:0]    req_off_s;
  logic [ADDR_W-1:0]   req_base_s;
  logic [3:0]          req_nbytes_s;
  logic                req_err_s;
  logic                req_split_s;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 4'd4;
      2'd1:    return 4'd2;
      2'd2:    return 4'd1;
      default: return 4'd8;
    endcase
  endfunction

  // Field bytes are pulled from a two-beat window in address order, then extended.
  function automatic logic [DATA_W-1:0] extract(
    input logic [DATA_W-1:0] b0,
    input logic [DATA_W-1:0] b1,
    input logic [OFF_W-1:0]  off,
    input logic [3:0]        nbytes,
    input logic              uns
  );
    logic [2*DATA_W-1:0] win;
    logic [63:0]         field;
    logic [DATA_W-1:0]   res;
    logic                msb;
    int                  nb;
    int                  pos;
    nb = int'(nbytes);
    if (BIG_ENDIAN != 0) win = {b0, b1};
    else                 win = {b1, b0};
    field = 64'd0;
    for (int k = 0; k < 8; k++) begin
      pos = int'(off) + k;
      if (k < nb && pos < 2 * NB) begin
        if (BIG_ENDIAN != 0) field[(nb-1-k)*8 +: 8] = win[(2*NB-1-pos)*8 +: 8];
        else                 field[k*8 +: 8]        = win[pos*8 +: 8];
      end
    end
    msb = field[nb*8-1];
    for (int j = 0; j < DATA_W; j++) begin
      res[j] = (j < nb * 8) ? field[j] : (~uns & msb);
    end
    return res;
  endfunction

  // Accept-time decode of offset, size, legality and beat crossing.
  always_comb begin
    req_off_s    = req_addr[OFF_W-1:0];
    req_base_s   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    req_nbytes_s = size_bytes(req_size);
    req_err_s    = 1'b0;
    if (req_size == 2'd3 && DATA_W == 32) begin
      req_err_s = 1'b1;
    end else if (MISALIGN_EN == 0 &&
                 ((4'(req_off_s) & (req_nbytes_s - 4'd1)) != 4'd0)) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = 1'b0;
    end
    req_split_s = (5'(req_off_s) + 5'(req_nbytes_s)) > 5'(NB);
  end

  // Control FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      base_r      <= {ADDR_W{1'b0}};
      off_r       <= {OFF_W{1'b0}};
      nbytes_r    <= 4'd0;
      uns_r       <= 1'b0;
      split_r     <= 1'b0;
      beat0_r     <= {DATA_W{1'b0}};
      req_ready_r <= 1'b1;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            base_r      <= req_base_s;
            off_r       <= req_off_s;
            nbytes_r    <= req_nbytes_s;
            uns_r       <= req_unsigned;
            split_r     <= req_split_s;
            req_ready_r <= 1'b0;
            if (req_err_s) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= {DATA_W{1'b0}};
              state_r     <= RESP;
            end else begin
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= req_base_s;
              state_r     <= RD0;
            end
          end
        end
        RD0: begin
          mem_rd_en_r <= 1'b0;
          mem_addr_r  <= {ADDR_W{1'b0}};
          state_r     <= WAIT0;
        end
        WAIT0: begin
          if (mem_rd_valid) begin
            beat0_r <= mem_rd_data;
            if (split_r) begin
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= base_r + ADDR_W'(NB);
              state_r     <= RD1;
            end else begin
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= extract(mem_rd_data, {DATA_W{1'b0}}, off_r, nbytes_r, uns_r);
              state_r     <= RESP;
            end
          end
        end
        RD1: begin
          mem_rd_en_r <= 1'b0;
          mem_addr_r  <= {ADDR_W{1'b0}};
          state_r     <= WAIT1;
        end
        WAIT1: begin
          if (mem_rd_valid) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= extract(beat0_r, mem_rd_data, off_r, nbytes_r, uns_r);
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          mem_rd_en_r <= 1'b0;
          mem_addr_r  <= {ADDR_W{1'b0}};
          rsp_valid_r <= 1'b0;
          rsp_data_r  <= {DATA_W{1'b0}};
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign mem_rd_en = mem_rd_en_r;
  assign mem_addr  = mem_addr_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit: four configurations share one stimulus
// driver, one memory model and one monitor, selected by sel.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_ready;
  logic        mem_rd_valid = 1'b0;
  logic [63:0] mem_rd_data = 64'd0;
  logic [1:0]  sel = 2'd0;

  logic        req_ready_a [4];
  logic        mem_rd_en_a [4];
  logic        rsp_valid_a [4];
  logic        rsp_err_a   [4];
  logic [31:0] mem_addr_a  [4];
  logic [31:0] rsp_data32  [3];
  logic [63:0] rsp_data64;

  logic        req_ready_m, mem_rd_en_m, rsp_valid_m, rsp_err_m;
  logic [31:0] mem_addr_m;
  logic [63:0] rsp_data_m;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q  [$];
  logic [31:0] addr_q [$];
  logic [63:0] beat_q [$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   mem_lat = 1;
  int   mem_cnt = 0;
  logic [63:0] mem_pend = 64'd0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  mem_load_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .MISALIGN_EN(1)) u_be32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && (sel == 2'd0)), .req_ready(req_ready_a[0]),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_rd_en(mem_rd_en_a[0]), .mem_addr(mem_addr_a[0]),
    .mem_rd_valid(mem_rd_valid && (sel == 2'd0)), .mem_rd_data(mem_rd_data[31:0]),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data32[0]), .rsp_err(rsp_err_a[0]));

  mem_load_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(0), .MISALIGN_EN(1)) u_le32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && (sel == 2'd1)), .req_ready(req_ready_a[1]),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_rd_en(mem_rd_en_a[1]), .mem_addr(mem_addr_a[1]),
    .mem_rd_valid(mem_rd_valid && (sel == 2'd1)), .mem_rd_data(mem_rd_data[31:0]),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data32[1]), .rsp_err(rsp_err_a[1]));

  mem_load_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .MISALIGN_EN(0)) u_strict32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && (sel == 2'd2)), .req_ready(req_ready_a[2]),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_rd_en(mem_rd_en_a[2]), .mem_addr(mem_addr_a[2]),
    .mem_rd_valid(mem_rd_valid && (sel == 2'd2)), .mem_rd_data(mem_rd_data[31:0]),
    .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready), .rsp_data(rsp_data32[2]), .rsp_err(rsp_err_a[2]));

  mem_load_unit #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1), .MISALIGN_EN(1)) u_be64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && (sel == 2'd3)), .req_ready(req_ready_a[3]),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_rd_en(mem_rd_en_a[3]), .mem_addr(mem_addr_a[3]),
    .mem_rd_valid(mem_rd_valid && (sel == 2'd3)), .mem_rd_data(mem_rd_data),
    .rsp_valid(rsp_valid_a[3]), .rsp_ready(rsp_ready), .rsp_data(rsp_data64), .rsp_err(rsp_err_a[3]));

  always_comb begin
    req_ready_m = req_ready_a[sel];
    mem_rd_en_m = mem_rd_en_a[sel];
    rsp_valid_m = rsp_valid_a[sel];
    rsp_err_m   = rsp_err_a[sel];
    mem_addr_m  = mem_addr_a[sel];
    case (sel)
      2'd0:    rsp_data_m = {32'd0, rsp_data32[0]};
      2'd1:    rsp_data_m = {32'd0, rsp_data32[1]};
      2'd2:    rsp_data_m = {32'd0, rsp_data32[2]};
      default: rsp_data_m = rsp_data64;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] next_beat();
    if (beat_q.size() > 0) return beat_q.pop_front();
    return 64'd0;
  endfunction

  // Memory model: returns one beat per read strobe after mem_lat cycles.
  always @(posedge clk) begin
    mem_rd_valid <= 1'b0;
    if (mem_cnt == 1) begin
      mem_rd_valid <= 1'b1;
      mem_rd_data  <= mem_pend;
      mem_cnt      <= 0;
    end else if (mem_cnt > 1) begin
      mem_cnt <= mem_cnt - 1;
    end
    if (mem_rd_en_m) begin
      if (mem_lat == 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= next_beat();
      end else begin
        mem_pend <= next_beat();
        mem_cnt  <= mem_lat - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks reads against addr_q and responses against exp_q.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_req_ready", 64'(req_ready_m), 64'd1);
      chk("reset_ctrl", 64'({mem_rd_en_m, rsp_valid_m, rsp_err_m}), 64'd0);
      chk("reset_rsp_data", rsp_data_m, 64'd0);
      prev_valid = 1'b0;
    end else begin
      if (mem_rd_en_m) begin
        if (addr_q.size() == 0) chk("unexpected_read", 64'(mem_rd_en_m), 64'd0);
        else                    chk("mem_addr", 64'(mem_addr_m), 64'(addr_q.pop_front()));
      end
      if (rsp_valid_m) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid_m), 64'd0);
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
          chk("rsp_data", rsp_data_m, exp_q[0].data);
          chk("rsp_err", 64'(rsp_err_m), 64'(exp_q[0].err));
          chk("busy_req_ready", 64'(req_ready_m), 64'd0);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = rsp_valid_m && !rsp_ready;
      if (req_valid && req_ready_m) acc_cyc = cyc;
    end
  end

  task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [63:0] d, input logic er, input int lat,
                       input int nrd, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [63:0] b0, input logic [63:0] b1, input logic push_exp);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    sel = s; req_addr = a; req_size = sz; req_unsigned = u;
    if (nrd > 0) begin addr_q.push_back(a0); beat_q.push_back(b0); end
    if (nrd > 1) begin addr_q.push_back(a1); beat_q.push_back(b1); end
    if (push_exp) begin
      e.data = d; e.err = er; e.lat = lat;
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready_m && n < 20) begin @(negedge clk); n++; end
    if (!req_ready_m) chk("accept_timeout", 64'(req_ready_m), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_size = 2'd0;
    req_unsigned = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Big-endian 32-bit: byte/half loads, split loads, address wrap, size-3 error
    issue(2'd0, 32'h1002, 2'd2, 1'b0, 64'hFFFFFF83, 1'b0, 3, 1, 32'h1000, 32'h0, 64'h11228344, 64'h0, 1'b1); drain();
    issue(2'd0, 32'h1002, 2'd2, 1'b1, 64'h00000083, 1'b0, 3, 1, 32'h1000, 32'h0, 64'h11228344, 64'h0, 1'b1); drain();
    issue(2'd0, 32'h1002, 2'd1, 1'b0, 64'hFFFF8344, 1'b0, 3, 1, 32'h1000, 32'h0, 64'h11228344, 64'h0, 1'b1); drain();
    issue(2'd0, 32'h1003, 2'd0, 1'b0, 64'hDD112233, 1'b0, 5, 2, 32'h1000, 32'h1004, 64'hAABBCCDD, 64'h11223344, 1'b1); drain();
    issue(2'd0, 32'hFFFFFFFF, 2'd0, 1'b0, 64'h04050607, 1'b0, 5, 2, 32'hFFFFFFFC, 32'h0, 64'h01020304, 64'h05060708, 1'b1); drain();
    issue(2'd0, 32'h1000, 2'd3, 1'b0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0, 64'h0, 64'h0, 1'b1); drain();
    // Little-endian 32-bit
    issue(2'd1, 32'h1002, 2'd1, 1'b0, 64'h00001122, 1'b0, 3, 1, 32'h1000, 32'h0, 64'h11228344, 64'h0, 1'b1); drain();
    issue(2'd1, 32'h1003, 2'd0, 1'b0, 64'h223344AA, 1'b0, 5, 2, 32'h1000, 32'h1004, 64'hAABBCCDD, 64'h11223344, 1'b1); drain();
    // Misalignment disabled
    issue(2'd2, 32'h1001, 2'd1, 1'b0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0, 64'h0, 64'h0, 1'b1); drain();
    issue(2'd2, 32'h1004, 2'd0, 1'b0, 64'h80000001, 1'b0, 3, 1, 32'h1004, 32'h0, 64'h80000001, 64'h0, 1'b1); drain();
    // 64-bit big-endian
    issue(2'd3, 32'h1004, 2'd3, 1'b0, 64'h445566778899AABB, 1'b0, 5, 2, 32'h1000, 32'h1008,
          64'h0011223344556677, 64'h8899AABBCCDDEEFF, 1'b1); drain();
    issue(2'd3, 32'h1004, 2'd0, 1'b0, 64'hFFFFFFFF8899AABB, 1'b0, 3, 1, 32'h1000, 32'h0, 64'h001122338899AABB, 64'h0, 1'b1); drain();
    issue(2'd3, 32'h1007, 2'd2, 1'b1, 64'h00000000000000BB, 1'b0, 3, 1, 32'h1000, 32'h0, 64'h001122338899AABB, 64'h0, 1'b1); drain();

    // Backpressure: rsp_ready low for three valid cycles
    rsp_ready = 1'b0;
    issue(2'd0, 32'h2000, 2'd2, 1'b0, 64'hFFFFFF80, 1'b0, 3, 1, 32'h2000, 32'h0, 64'h80000000, 64'h0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid_m && n < 20) begin @(negedge clk); n++; end
    chk("bp_rsp_valid", 64'(rsp_valid_m), 64'd1);
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // Reset in WAIT0 with a slow memory; the late beat must be ignored
    mem_lat = 3;
    issue(2'd0, 32'h1000, 2'd2, 1'b0, 64'h0, 1'b0, 0, 1, 32'h1000, 32'h0, 64'h11228344, 64'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_req_ready", 64'(req_ready_m), 64'd1);
    chk("async_reset_outputs", {61'd0, mem_rd_en_m, rsp_valid_m, rsp_err_m}, 64'd0);
    chk("async_reset_rsp_data", rsp_data_m, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    mem_lat = 1;
    chk("post_reset_req_ready", 64'(req_ready_m), 64'd1);
    chk("leftover_reads", 64'(addr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Sequential load unit between the CPU memory stage and the data memory port. It accepts a load request, issues one or two word-aligned reads, and merges the returned beats. It then extracts, aligns and sign/zero-extends the requested byte, half, word or doubleword. Endianness and data width are parametrised, and misaligned loads can be split into two reads or flagged as errors.

## Interface
- DATA_W, 32: memory beat width; legal values 32 or 64. Beat holds NB = DATA_W/8 bytes.
- ADDR_W, 32: byte-address width.
- BIG_ENDIAN, 1: 1 = byte 0 is the most significant byte of a beat; 0 = byte 0 is the least significant byte.
- MISALIGN_EN, 1: 1 = misaligned loads that cross a beat are split into two reads; 0 = loads with offset not a multiple of the size return an error.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0 = word (4 B), 1 = half, 2 = byte, 3 = doubleword (8 B).
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  beat-aligned address; low log2(NB) bits are 0.
- mem_rd_valid  in  1  read data valid; exactly one pulse per mem_rd_en, at least 1 cycle later.
- mem_rd_data  in  DATA_W  read data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  DATA_W  extended load result.
- rsp_err  out  1  request was illegal; rsp_data = 0.

## Operation
- States: IDLE, RD0, WAIT0, RD1, WAIT1, RESP.
- IDLE: req_ready = 1; all other outputs are 0. On accept, latch offset = req_addr[log2(NB)-1:0], base = req_addr with offset bits cleared, size, and unsigned flag.
- Error check at accept time. An error occurs when size 3 is requested with DATA_W = 32, or when MISALIGN_EN = 0 and offset mod nbytes != 0. On error go to RESP with rsp_err = 1 and rsp_data = 0; no memory access is made.
- Split = (offset + nbytes > NB). Only possible when MISALIGN_EN = 1.
- RD0: mem_rd_en = 1, mem_addr = base, then go to WAIT0. WAIT0: on mem_rd_valid, capture beat0; go to RD1 if split, else RESP.
- RD1: mem_rd_en = 1, mem_addr = base + NB, wrapping modulo 2^ADDR_W, then go to WAIT1. WAIT1: on mem_rd_valid, capture beat1 and go to RESP.
- Extraction works on a 2·NB-byte window:
  - Big-endian window is {beat0, beat1}. Field = window bytes offset .. offset+nbytes-1, with the byte at the lower address most significant.
  - Little-endian window is {beat1, beat0}. The byte at the lower address is least significant.
  - Without a split, beat1 is treated as 0.
- Extension: the field is right-justified into DATA_W. Upper bits are 0 if unsigned, else copies of the field MSB. A word load on DATA_W = 64 is extended to 64 bits.
- RESP: rsp_valid = 1. rsp_data and rsp_err stay stable until rsp_ready, then return to IDLE. There is no request pipelining: req_ready = 0 outside IDLE.
- mem_rd_valid is ignored in IDLE, RD0, RD1 and RESP.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, req_ready = 1, and every other output and internal register is 0. Reset mid-transaction drops the request; a late mem_rd_valid after release is ignored.
- Let memory latency L be the cycles from mem_rd_en to mem_rd_valid. With accept at cycle 0:
  - mem_rd_en at cycle 1.
  - Non-split: rsp_valid at cycle 2+L.
  - Split: second mem_rd_en at 2+L, rsp_valid at 3+2L.
  - Error: rsp_valid at cycle 1.
- With rsp_ready held high, the earliest next accept is the cycle after the response handshake.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or mem_rd_data to any output.

## Test plan
All scenarios use DATA_W = 32, BIG_ENDIAN = 1, L = 1 unless stated.
- Reset: assert rst_n mid-WAIT0 -> req_ready = 1 and mem_rd_en = rsp_valid = rsp_data = rsp_err = 0 immediately. After release, the stale mem_rd_valid is ignored and no rsp_valid appears.
- Byte load, addr 0x1002, memory word 0x11228344 -> mem_addr = 0x1000, rsp_data = 0xFFFFFF83 at cycle 3. With req_unsigned = 1 -> 0x00000083.
- Half load, addr 0x1002, same word -> rsp_data = 0xFFFF8344. With BIG_ENDIAN = 0 -> bytes 0x22, 0x11 give rsp_data = 0x00001122.
- Split word load, addr 0x1003, beats 0xAABBCCDD then 0x11223344 -> reads at 0x1000 and 0x1004, rsp_data = 0xDD112233, rsp_valid at cycle 5.
- MISALIGN_EN = 0, half load at 0x1001 -> no mem_rd_en, rsp_err = 1, rsp_data = 0, rsp_valid at cycle 1.
- Backpressure: hold rsp_ready low for 3 cycles on a signed byte load returning 0x80 -> rsp_valid, rsp_data = 0xFFFFFF80 and req_ready = 0 all stable. Then DATA_W = 64, doubleword at offset 4 -> split, merged result matches the expected 8 bytes.
